tmds_rx_channel: RTL and testbench



---
 rtl/tmds_pkg.sv | 27 ++
 rtl/tmds_symbol_decode.sv | 42 ++++
 rtl/tmds_rx_channel.sv | 160 ++++++++++++++++
 tb/tb_tmds_rx_channel.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions for the receive lane and the symbol decoder.
//   TMDS_SYM_W       : width of one TMDS symbol on the wire.
//   TOK_C00..TOK_C11 : the four DVI control tokens, bit 0 earliest in time.
//   tmds_ctrl_e      : encoding of the (c1,c0) pair carried by a token.
//   rx_state_e       : alignment FSM states.
package tmds_pkg;

  localparam int TMDS_SYM_W = 10;

  localparam logic [TMDS_SYM_W-1:0] TOK_C00 = 10'b1101010100;
  localparam logic [TMDS_SYM_W-1:0] TOK_C01 = 10'b0010101011;
  localparam logic [TMDS_SYM_W-1:0] TOK_C10 = 10'b0101010100;
  localparam logic [TMDS_SYM_W-1:0] TOK_C11 = 10'b1010101011;

  typedef enum logic [1:0] {
    CTRL_C00 = 2'b00,
    CTRL_C01 = 2'b01,
    CTRL_C10 = 2'b10,
    CTRL_C11 = 2'b11
  } tmds_ctrl_e;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } rx_state_e;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder.
//   sym     in  10 : aligned symbol.
//   is_ctrl out 1  : symbol is one of the four control tokens.
//   ctrl    out 2  : (c1,c0) carried by the token; 0 when not a token.
//   data    out 8  : TMDS-decoded byte (meaningful only when is_ctrl is 0).
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [TMDS_SYM_W-1:0] sym,
  output logic                  is_ctrl,
  output logic [1:0]            ctrl,
  output logic [7:0]            data
);

  logic [7:0] q;

  always_comb begin
    is_ctrl = 1'b1;
    ctrl    = CTRL_C00;
    case (sym)
      TOK_C00: ctrl = CTRL_C00;
      TOK_C01: ctrl = CTRL_C01;
      TOK_C10: ctrl = CTRL_C10;
      TOK_C11: ctrl = CTRL_C11;
      default: begin
        is_ctrl = 1'b0;
        ctrl    = CTRL_C00;
      end
    endcase
  end

  // Bit 9 flags an inverted payload, bit 8 selects XOR (1) or XNOR (0) chaining.
  always_comb begin
    q       = sym[9] ? ~sym[7:0] : sym[7:0];
    data    = 8'h00;
    data[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

endmodule

// File: rtl/tmds_rx_channel.sv
// One TMDS receive lane: word alignment by control-token search, then decode.
//   clk    in  1  : pixel clock, sym_in synchronous to it.
//   resetn in  1  : asynchronous active-low reset.
//   sym_in in  10 : raw deserialised bits, bit 0 earliest in time.
//   data   out 8  : decoded pixel byte (0 while a token is output).
//   ctrl   out 2  : last decoded control value (c1,c0).
//   de     out 1  : current output is a data symbol and the lane is locked.
//   locked out 1  : alignment achieved.
//   offset out 4  : current bit-slip offset 0..9.
module tmds_rx_channel
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [TMDS_SYM_W-1:0] sym_in,
  output logic [7:0]            data,
  output logic [1:0]            ctrl,
  output logic                  de,
  output logic                  locked,
  output logic [3:0]            offset
);

  localparam int TOK_W     = (LOCK_COUNT > 2) ? $clog2(LOCK_COUNT) : 1;
  localparam int IDLE_SPAN = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int IDLE_W    = $clog2(IDLE_SPAN);

  // Thresholds are one below the "reaching" value because the compare is
  // made against the count before this cycle's increment.
  localparam logic [TOK_W-1:0]  TOK_LAST    = TOK_W'(LOCK_COUNT - 1);
  localparam logic [IDLE_W-1:0] SEARCH_LAST = IDLE_W'(SEARCH_TIMEOUT - 2);
  localparam logic [IDLE_W-1:0] LOSS_LAST   = IDLE_W'(LOSS_TIMEOUT - 2);

  function automatic logic [TOK_W-1:0] sat_inc_tok(input logic [TOK_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [IDLE_W-1:0] sat_inc_idle(input logic [IDLE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [3:0] next_offset(input logic [3:0] v);
    return (v == 4'd9) ? 4'd0 : v + 4'd1;
  endfunction

  logic [TMDS_SYM_W-1:0] prev_p0;
  logic [TMDS_SYM_W-1:0] aligned_p1;
  logic [2*TMDS_SYM_W-1:0] window;
  logic [4:0]            sel_lsb;
  logic [TMDS_SYM_W-1:0] aligned_sel;

  logic       dec_is_ctrl;
  logic [1:0] dec_ctrl;
  logic [7:0] dec_data;

  rx_state_e         state, state_next;
  logic [TOK_W-1:0]  tok_cnt, tok_next;
  logic [IDLE_W-1:0] idle_cnt, idle_next;
  logic [3:0]        offset_next;

  // Offset k picks a symbol that started k bits earlier, i.e. in prev_p0.
  assign window      = {sym_in, prev_p0};
  assign sel_lsb     = 5'd10 - {1'b0, offset};
  assign aligned_sel = TMDS_SYM_W'(window >> sel_lsb);

  // ---- stage p0 -> p1: bit-slip alignment ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_p0    <= '0;
      aligned_p1 <= '0;
    end else begin
      prev_p0    <= sym_in;
      aligned_p1 <= aligned_sel;
    end
  end

  tmds_symbol_decode u_decode (
    .sym     (aligned_p1),
    .is_ctrl (dec_is_ctrl),
    .ctrl    (dec_ctrl),
    .data    (dec_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_SEARCH;
      tok_cnt  <= '0;
      idle_cnt <= '0;
      offset   <= 4'd0;
    end else begin
      state    <= state_next;
      tok_cnt  <= tok_next;
      idle_cnt <= idle_next;
      offset   <= offset_next;
    end
  end

  always_comb begin
    state_next  = state;
    tok_next    = tok_cnt;
    idle_next   = idle_cnt;
    offset_next = offset;
    case (state)
      ST_SEARCH: begin
        if (dec_is_ctrl) begin
          idle_next = '0;
          if (tok_cnt == TOK_LAST) begin
            state_next = ST_LOCKED;
            tok_next   = '0;
          end else begin
            tok_next = sat_inc_tok(tok_cnt);
          end
        end else begin
          tok_next = '0;
          if (idle_cnt >= SEARCH_LAST) begin
            offset_next = next_offset(offset);
            idle_next   = '0;
          end else begin
            idle_next = sat_inc_idle(idle_cnt);
          end
        end
      end
      ST_LOCKED: begin
        if (dec_is_ctrl) begin
          idle_next = '0;
        end else if (idle_cnt >= LOSS_LAST) begin
          state_next = ST_SEARCH;
          idle_next  = '0;
          tok_next   = '0;
        end else begin
          idle_next = sat_inc_idle(idle_cnt);
        end
      end
      default: state_next = ST_SEARCH;
    endcase
  end

  assign locked = (state == ST_LOCKED);

  // ---- stage p1 -> p2: decoded outputs ----
  // de follows the next lock state so it rises and falls together with locked.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data <= 8'h00;
      ctrl <= 2'b00;
      de   <= 1'b0;
    end else if (dec_is_ctrl) begin
      data <= 8'h00;
      ctrl <= dec_ctrl;
      de   <= 1'b0;
    end else begin
      data <= dec_data;
      de   <= (state_next == ST_LOCKED);
    end
  end

endmodule

// File: tb/tb_tmds_rx_channel.sv
// Directed bench for tmds_rx_channel. dut_a uses short timeouts for search
// and loss scenarios; dut_b uses the default timeouts for a video-like stream.
module tb_tmds_rx_channel;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [9:0] sym_in = 10'h000;

  logic [7:0] data_a, data_b;
  logic [1:0] ctrl_a, ctrl_b;
  logic       de_a, de_b, locked_a, locked_b;
  logic [3:0] offset_a, offset_b;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] D1  = 10'b0100000000;  // decodes to 8'h00
  localparam logic [9:0] D2  = 10'b1011111111;  // decodes to 8'hFE

  always #5 clk = ~clk;

  tmds_rx_channel #(.LOCK_COUNT(8), .SEARCH_TIMEOUT(16), .LOSS_TIMEOUT(64)) dut_a (
    .clk    (clk),
    .resetn (resetn),
    .sym_in (sym_in),
    .data   (data_a),
    .ctrl   (ctrl_a),
    .de     (de_a),
    .locked (locked_a),
    .offset (offset_a)
  );

  tmds_rx_channel dut_b (
    .clk    (clk),
    .resetn (resetn),
    .sym_in (sym_in),
    .data   (data_b),
    .ctrl   (ctrl_b),
    .de     (de_b),
    .locked (locked_b),
    .offset (offset_b)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic [9:0] w);
    sym_in = w;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    logic [9:0] rot;
    logic [3:0] prev_off;
    int         steps;
    int         bad_steps;
    int         rises;
    int         drops;
    logic       was_locked;
    int         de_cnt [4];
    logic [9:0] w;
    int         idx;

    // Reset held with random input
    for (int i = 0; i < 5; i++) tick(10'($urandom));
    check("rst_data",   16'(data_a),   16'h0);
    check("rst_ctrl",   16'(ctrl_a),   16'h0);
    check("rst_de",     16'(de_a),     16'h0);
    check("rst_locked", 16'(locked_a), 16'h0);
    check("rst_offset", 16'(offset_a), 16'h0);
    resetn = 1'b1;

    // Aligned lock
    for (int i = 0; i < 8; i++) tick(T00);
    check("al_pre_locked", 16'(locked_a), 16'h0);
    check("al_pre_ctrl",   16'(ctrl_a),   16'h0);
    tick(D1);
    check("al_locked",     16'(locked_a), 16'h1);
    check("al_tok_ctrl",   16'(ctrl_a),   16'h0);
    check("al_tok_de",     16'(de_a),     16'h0);
    tick(D2);
    check("al_d1_data",    16'(data_a),   16'h00);
    check("al_d1_de",      16'(de_a),     16'h1);
    tick(T01);
    check("al_d2_data",    16'(data_a),   16'hFE);
    check("al_d2_de",      16'(de_a),     16'h1);
    check("al_offset",     16'(offset_a), 16'h0);

    // Token decode while locked
    tick(T10);
    check("tk01_ctrl", 16'(ctrl_a), 16'h1);
    check("tk01_de",   16'(de_a),   16'h0);
    check("tk01_data", 16'(data_a), 16'h0);
    tick(T11);
    check("tk10_ctrl", 16'(ctrl_a), 16'h2);
    check("tk10_de",   16'(de_a),   16'h0);
    tick(D2);
    check("tk11_ctrl", 16'(ctrl_a), 16'h3);
    check("tk11_de",   16'(de_a),   16'h0);
    tick(D1);
    check("tkhold_ctrl", 16'(ctrl_a), 16'h3);
    check("tkhold_data", 16'(data_a), 16'hFE);
    check("tkhold_de",   16'(de_a),   16'h1);

    // Asynchronous reset mid-cycle while locked
    #2;
    resetn = 1'b0;
    #1;
    check("arst_data",   16'(data_a),   16'h0);
    check("arst_ctrl",   16'(ctrl_a),   16'h0);
    check("arst_de",     16'(de_a),     16'h0);
    check("arst_locked", 16'(locked_a), 16'h0);
    check("arst_offset", 16'(offset_a), 16'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Misaligned search: each symbol starts at sym_in bit 3
    rot = {T00[6:0], T00[9:7]};
    prev_off = 4'd0;
    steps = 0;
    bad_steps = 0;
    for (int i = 0; i < 400 && !locked_a; i++) begin
      tick(rot);
      if (offset_a != prev_off) begin
        steps++;
        if (offset_a != ((prev_off == 4'd9) ? 4'd0 : prev_off + 4'd1)) bad_steps++;
        prev_off = offset_a;
      end
    end
    check("mis_locked",    16'(locked_a), 16'h1);
    check("mis_offset",    16'(offset_a), 16'h7);
    check("mis_ctrl",      16'(ctrl_a),   16'h0);
    check("mis_steps",     16'(steps),    16'd7);
    check("mis_bad_steps", 16'(bad_steps), 16'd0);

    // Loss of lock
    pulse_reset();
    for (int i = 0; i < 9; i++) tick(T00);
    check("loss_locked0", 16'(locked_a), 16'h1);
    for (int i = 0; i < 60; i++) tick(D1);
    check("loss_locked60", 16'(locked_a), 16'h1);
    check("loss_de60",     16'(de_a),     16'h1);
    for (int i = 0; i < 4; i++) tick(D1);
    check("loss_locked64", 16'(locked_a), 16'h0);
    check("loss_de64",     16'(de_a),     16'h0);
    check("loss_offset64", 16'(offset_a), 16'h0);
    for (int i = 0; i < 10; i++) tick(D1);
    check("loss_offset_hold", 16'(offset_a), 16'h0);
    for (int i = 0; i < 6; i++) tick(D1);
    check("loss_offset_adv",  16'(offset_a), 16'h1);

    // Video-like stream on the default-timeout instance
    pulse_reset();
    rises = 0;
    drops = 0;
    was_locked = 1'b0;
    for (int l = 0; l < 4; l++) de_cnt[l] = 0;
    for (int e = 1; e <= 3202; e++) begin
      idx = e - 1;
      if (idx < 3200 && (idx % 800) >= 160) w = (idx % 2 == 1) ? D2 : D1;
      else w = T00;
      tick(w);
      if (locked_b && !was_locked) rises++;
      if (!locked_b && was_locked) drops++;
      was_locked = locked_b;
      if (e >= 2 && (e - 2) < 3200 && de_b) de_cnt[(e - 2) / 800]++;
    end
    check("vid_rises",  16'(rises),    16'd1);
    check("vid_drops",  16'(drops),    16'd0);
    check("vid_locked", 16'(locked_b), 16'h1);
    check("vid_offset", 16'(offset_b), 16'h0);
    check("vid_de_l0",  16'(de_cnt[0]), 16'd640);
    check("vid_de_l1",  16'(de_cnt[1]), 16'd640);
    check("vid_de_l2",  16'(de_cnt[2]), 16'd640);
    check("vid_de_l3",  16'(de_cnt[3]), 16'd640);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
